rv_bus_arbiter: RTL and testbench
=================================

# rv_bus_arbiter

Two-master, one-slave arbiter that shares the core's single memory port between the instruction fetch unit and the load/store unit. It sits between the fetch stage's `o_addr`/`o_cyc`/`i_ack`/`i_instruction` bus, the LSU data bus, and the external memory. The arbiter keeps one transaction outstanding at a time. It also absorbs fetches cancelled by a PC redirect, so a stale ack never reaches the fetch stage.

## Interface
- `RESET_ADDR`, default `32'h0000_0000`: reset value of `o_mem_addr`.
- `i_clk`  in  1  core clock; all state updates on its rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_fetch_addr`  in  32  fetch address; held by the fetch stage until ack.
- `i_fetch_cyc`  in  1  fetch request.
- `i_fetch_abort`  in  1  PC redirect (pc_select); cancels the fetch in flight.
- `o_fetch_ack`  out  1  fetch completion.
- `o_fetch_data`  out  32  instruction word; valid with `o_fetch_ack`.
- `i_data_addr`  in  32  LSU address.
- `i_data_cyc`  in  1  LSU request.
- `i_data_we`  in  1  LSU write enable.
- `i_data_sel`  in  4  LSU byte enables.
- `i_data_wdata`  in  32  LSU write data.
- `o_data_ack`  out  1  LSU completion.
- `o_data_rdata`  out  32  LSU read data; valid with `o_data_ack`.
- `o_mem_addr`  out  32  memory address (registered).
- `o_mem_cyc`  out  1  memory cycle valid (registered).
- `o_mem_we`  out  1  memory write enable (registered).
- `o_mem_sel`  out  4  memory byte enables (registered).
- `o_mem_wdata`  out  32  memory write data (registered).
- `i_mem_ack`  in  1  memory ack; single-cycle pulse per transaction.
- `i_mem_rdata`  in  32  memory read data; valid with `i_mem_ack`.

## Operation
- FSM states:
  - IDLE
  - FETCH: fetch granted
  - DATA: LSU granted
  - FLUSH: aborted fetch draining
- Arbitration happens in IDLE, and in FETCH/DATA on the cycle `i_mem_ack` is high (back-to-back, no bubble).
  - Only one requester has `cyc` high: it is granted.
  - Both have `cyc` high: the policy is set by the configuration macro.
  - Neither: go to IDLE.
- On grant, the requester's addr/we/sel/wdata are latched into the `o_mem_*` registers and `o_mem_cyc` is set to 1.
  - A fetch grant forces `o_mem_we`=0 and `o_mem_sel`=4'hF.
- On return to IDLE, `o_mem_cyc` is cleared; `o_mem_addr`/`o_mem_we`/`o_mem_sel`/`o_mem_wdata` hold their values.
- Ack routing is combinational:
  - `o_fetch_ack` = `i_mem_ack` & FETCH & !`i_fetch_abort`.
  - `o_data_ack` = `i_mem_ack` & DATA.
  - `o_fetch_data` and `o_data_rdata` are driven by `i_mem_rdata` unconditionally.
- Fetch abort:
  - In FETCH with `i_fetch_abort`=1 and `i_mem_ack`=0: go to FLUSH. `o_mem_cyc` stays high with the latched address.
  - In FLUSH, when `i_mem_ack` arrives it is swallowed (no requester ack), then normal arbitration runs on that cycle.
  - `i_fetch_abort` coinciding with `i_mem_ack` in FETCH: the ack is suppressed; no FLUSH is entered.
  - `i_fetch_abort` in IDLE or DATA: no effect.
- A fetch request that is not granted is not latched; the fetch stage keeps `cyc` high.
- `i_data_cyc` dropping mid-DATA is illegal (LSU holds until ack). Behaviour is undefined; the assertion bench flags it.

## Timing
- Reset values:
  - state IDLE, last-grant = DATA
  - `o_mem_cyc`=0, `o_mem_addr`=`RESET_ADDR`, `o_mem_we`=0, `o_mem_sel`=0, `o_mem_wdata`=0
- Reset asserted mid-transaction:
  - Immediate return to IDLE; an in-flight memory ack arriving after reset release is ignored (state IDLE).
  - `o_fetch_ack`/`o_data_ack` are 0 combinationally while `i_reset_n`=0.
- Latency:
  - Request seen in IDLE at cycle N: `o_mem_cyc`=1 from N+1.
  - Zero-wait memory acks at N+1, so the requester sees its ack at N+1 (1-cycle arbitration cost).
- Back-to-back: on an ack cycle with a pending request, the next transaction's `o_mem_*` is valid the following cycle. Sustained throughput with zero-wait memory is 1 transaction/cycle.
- FLUSH adds the remaining memory latency before any new grant.

## Configuration
- `ARBITER_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, grant the requester not granted last. The last-grant flag updates on every grant.
- `ARBITER_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the LSU always wins simultaneous requests. The last-grant flag is not implemented.

## Test plan
- Reset then lone fetch: `i_fetch_cyc`=1, `i_fetch_addr`=0x100, zero-wait memory acks with 0x00000013 -> `o_mem_addr`=0x100 and `o_mem_cyc`=1 one cycle after request; `o_fetch_ack`=1 with `o_fetch_data`=0x00000013; `o_mem_we`=0, `o_mem_sel`=4'hF.
- LSU write: addr 0x2000_0004, sel 4'b0011, wdata 0xDEAD_BEEF, memory 2 wait states -> `o_mem_*` holds those values for 3 cycles; `o_data_ack` pulses once; `o_fetch_ack` stays 0.
- Simultaneous requests held for 4 transactions:
  - Round-robin: grants alternate, starting with fetch (reset last-grant = DATA).
  - Fixed priority: all 4 grants go to the LSU before any fetch grant.
- Abort: fetch 0x200 granted, memory 3 wait states, `i_fetch_abort` pulsed one cycle later -> FLUSH; `o_mem_addr` stays 0x200 until ack; `o_fetch_ack` never asserts; the new fetch at 0x300 is issued the cycle after the swallowed ack.
- Abort coinciding with ack -> `o_fetch_ack`=0, no FLUSH, arbitration proceeds the same cycle.
- `i_reset_n` dropped while DATA waits -> `o_mem_cyc`=0 and state IDLE immediately; a late `i_mem_ack` after release produces no `o_data_ack`.

Source files
------------

// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter: shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Define ARBITER_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise the LSU has fixed priority.
module rv_bus_arbiter #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_fetch_addr,
  input  logic        i_fetch_cyc,
  input  logic        i_fetch_abort,
  output logic        o_fetch_ack,
  output logic [31:0] o_fetch_data,
  input  logic [31:0] i_data_addr,
  input  logic        i_data_cyc,
  input  logic        i_data_we,
  input  logic [3:0]  i_data_sel,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_ack,
  output logic [31:0] o_data_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_cyc,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_sel,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA,
    FLUSH
  } state_t;

  state_t state_q, state_d;
  logic   arb_en;
  logic   grant_fetch;
  logic   grant_data;
  logic   prefer_fetch;

`ifdef ARBITER_ROUND_ROBIN_EN
  // Set while the LSU holds the most recent grant; reset value lets fetch win first.
  logic last_data_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_data_q <= 1'b1;
    end else if (grant_fetch) begin
      last_data_q <= 1'b0;
    end else if (grant_data) begin
      last_data_q <= 1'b1;
    end
  end

  assign prefer_fetch = last_data_q;
`else
  assign prefer_fetch = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration runs in IDLE and on any ack cycle, so grants chain without a bubble.
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      IDLE:  arb_en = 1'b1;
      FETCH: begin
        if (i_mem_ack) begin
          arb_en = 1'b1;
        end else if (i_fetch_abort) begin
          state_d = FLUSH;
        end
      end
      DATA:    arb_en = i_mem_ack;
      FLUSH:   arb_en = i_mem_ack;
      default: arb_en = 1'b0;
    endcase
    grant_fetch = arb_en && i_fetch_cyc && (!i_data_cyc || prefer_fetch);
    grant_data  = arb_en && i_data_cyc && !grant_fetch;
    if (arb_en) begin
      if (grant_fetch) begin
        state_d = FETCH;
      end else if (grant_data) begin
        state_d = DATA;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mem_cyc   <= 1'b0;
      o_mem_addr  <= RESET_ADDR;
      o_mem_we    <= 1'b0;
      o_mem_sel   <= '0;
      o_mem_wdata <= '0;
    end else if (grant_fetch) begin
      o_mem_cyc  <= 1'b1;
      o_mem_addr <= i_fetch_addr;
      o_mem_we   <= 1'b0;
      o_mem_sel  <= '1;
    end else if (grant_data) begin
      o_mem_cyc   <= 1'b1;
      o_mem_addr  <= i_data_addr;
      o_mem_we    <= i_data_we;
      o_mem_sel   <= i_data_sel;
      o_mem_wdata <= i_data_wdata;
    end else if (arb_en) begin
      o_mem_cyc <= 1'b0;
    end
  end

  // FLUSH is never FETCH, so the ack of a cancelled fetch cannot leak to the fetch stage.
  assign o_fetch_ack  = i_mem_ack && (state_q == FETCH) && !i_fetch_abort;
  assign o_data_ack   = i_mem_ack && (state_q == DATA);
  assign o_fetch_data = i_mem_rdata;
  assign o_data_rdata = i_mem_rdata;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
// Scoreboard bench for rv_bus_arbiter: stimulus queues expected grants/acks, a monitor checks them.
module tb_rv_bus_arbiter;

  localparam logic [31:0] RST_ADDR = 32'h0000_1000;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic [31:0] i_fetch_addr;
  logic        i_fetch_cyc;
  logic        i_fetch_abort;
  logic        o_fetch_ack;
  logic [31:0] o_fetch_data;
  logic [31:0] i_data_addr;
  logic        i_data_cyc;
  logic        i_data_we;
  logic [3:0]  i_data_sel;
  logic [31:0] i_data_wdata;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic [31:0] o_mem_addr;
  logic        o_mem_cyc;
  logic        o_mem_we;
  logic [3:0]  o_mem_sel;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  rv_bus_arbiter #(.RESET_ADDR(RST_ADDR)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_fetch_addr  (i_fetch_addr),
    .i_fetch_cyc   (i_fetch_cyc),
    .i_fetch_abort (i_fetch_abort),
    .o_fetch_ack   (o_fetch_ack),
    .o_fetch_data  (o_fetch_data),
    .i_data_addr   (i_data_addr),
    .i_data_cyc    (i_data_cyc),
    .i_data_we     (i_data_we),
    .i_data_sel    (i_data_sel),
    .i_data_wdata  (i_data_wdata),
    .o_data_ack    (o_data_ack),
    .o_data_rdata  (o_data_rdata),
    .o_mem_addr    (o_mem_addr),
    .o_mem_cyc     (o_mem_cyc),
    .o_mem_we      (o_mem_we),
    .o_mem_sel     (o_mem_sel),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_ack     (i_mem_ack),
    .i_mem_rdata   (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          start;
  } grant_t;

  typedef struct {
    bit          fetch;
    logic [31:0] data;
  } ack_t;

  grant_t      gq[$];
  ack_t        aq[$];
  int          cyc_no = 0;
  int          tmo = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          done = 1'b0;
  logic [31:0] exp_wdata = '0;

  // Memory model: ack after mem_wait extra cycles; force_ack injects a stray ack.
  int          mem_wait = 0;
  int          mcnt = 0;
  bit          mprev = 1'b0;
  bit          force_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always @(posedge i_clk) cyc_no <= cyc_no + 1;

  always @(negedge i_clk) begin
    if (!o_mem_cyc) begin
      mcnt      = 0;
      i_mem_ack = force_ack;
    end else begin
      if (i_mem_ack || !mprev) mcnt = 0;
      else mcnt = mcnt + 1;
      i_mem_ack = (mcnt == mem_wait) || force_ack;
    end
    mprev       = o_mem_cyc;
    i_mem_rdata = mem_rdata;
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a, input int start);
    grant_t g;
    g.addr = a; g.we = 1'b0; g.sel = 4'hF; g.wdata = exp_wdata; g.start = start;
    gq.push_back(g);
  endtask

  task automatic push_data(input logic [31:0] a, input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, input int start);
    grant_t g;
    g.addr = a; g.we = we; g.sel = sel; g.wdata = wd; g.start = start;
    exp_wdata = wd;
    gq.push_back(g);
  endtask

  task automatic push_ack(input bit fetch, input logic [31:0] d);
    ack_t a;
    a.fetch = fetch; a.data = d;
    aq.push_back(a);
  endtask

  task automatic wait_ack(input bit fetch);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fetch ? o_fetch_ack : o_data_ack) return;
    end
    tmo++;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_no);
    end
  endtask

  // Monitor
  initial begin : monitor
    grant_t cur;
    grant_t g;
    ack_t   a;
    bit     prev_cyc;
    bit     prev_ack;
    prev_cyc = 1'b0;
    prev_ack = 1'b0;
    forever begin
      @(negedge i_clk);
      #2;
      if (done) break;
      if (!i_reset_n) begin
        check("reset_state",
              80'({o_mem_cyc, o_mem_we, o_mem_sel, o_mem_addr, o_mem_wdata, o_fetch_ack, o_data_ack}),
              80'({1'b0, 1'b0, 4'h0, RST_ADDR, 32'h0, 2'b00}));
        prev_cyc = 1'b0;
        prev_ack = 1'b0;
      end else begin
        if (o_mem_cyc && (!prev_cyc || prev_ack)) begin
          if (gq.size() == 0) begin
            check("unexpected_grant", 80'(o_mem_addr), 80'(32'hFFFF_FFFF) ^ 80'(o_mem_addr));
          end else begin
            g = gq.pop_front();
            check("grant_fields", 80'({o_mem_addr, o_mem_we, o_mem_sel, o_mem_wdata}),
                  80'({g.addr, g.we, g.sel, g.wdata}));
            check("grant_cycle", 80'(cyc_no), 80'(g.start));
            cur = g;
          end
        end else if (o_mem_cyc) begin
          check("hold", 80'({o_mem_addr, o_mem_we, o_mem_sel, o_mem_wdata}),
                80'({cur.addr, cur.we, cur.sel, cur.wdata}));
        end
        if (o_fetch_ack || o_data_ack) begin
          if (aq.size() == 0) begin
            check("unexpected_ack", 80'({o_fetch_ack, o_data_ack}), 80'(2'b00));
          end else begin
            a = aq.pop_front();
            check("ack", 80'({o_fetch_ack, o_data_ack, a.fetch ? o_fetch_data : o_data_rdata}),
                  80'({a.fetch, !a.fetch, a.data}));
          end
        end
        prev_cyc = o_mem_cyc;
        prev_ack = i_mem_ack;
      end
    end
    check("grants_left", 80'(gq.size()), 80'(0));
    check("acks_left", 80'(aq.size()), 80'(0));
    check("wait_timeouts", 80'(tmo), 80'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Stimulus
  initial begin : stimulus
    int c;
    i_fetch_addr = '0; i_fetch_cyc = 1'b0; i_fetch_abort = 1'b0;
    i_data_addr = '0; i_data_cyc = 1'b0; i_data_we = 1'b0; i_data_sel = '0; i_data_wdata = '0;
    #1 i_reset_n = 1'b0;
    repeat (3) tick();
    i_reset_n = 1'b1;
    tick();

    // Lone fetch, zero-wait memory
    mem_wait = 0; mem_rdata = 32'h0000_0013;
    c = cyc_no;
    i_fetch_addr = 32'h100; i_fetch_cyc = 1'b1;
    push_fetch(32'h100, c + 1);
    push_ack(1'b1, 32'h0000_0013);
    wait_ack(1'b1);
    i_fetch_cyc = 1'b0;
    tick();

    // LSU write, two wait states
    mem_wait = 2; mem_rdata = 32'h1234_5678;
    c = cyc_no;
    i_data_addr = 32'h2000_0004; i_data_we = 1'b1; i_data_sel = 4'b0011;
    i_data_wdata = 32'hDEAD_BEEF; i_data_cyc = 1'b1;
    push_data(32'h2000_0004, 1'b1, 4'b0011, 32'hDEAD_BEEF, c + 1);
    push_ack(1'b0, 32'h1234_5678);
    wait_ack(1'b0);
    i_data_cyc = 1'b0;
    tick();

    // Simultaneous requests, four back-to-back grants, then the leftover fetch
    mem_wait = 0; mem_rdata = 32'hCAFE_0001;
    c = cyc_no;
    i_fetch_addr = 32'h400; i_fetch_cyc = 1'b1;
    i_data_addr = 32'h3000_0000; i_data_we = 1'b0; i_data_sel = 4'b1100;
    i_data_wdata = 32'h1111_1111; i_data_cyc = 1'b1;
`ifdef ARBITER_ROUND_ROBIN_EN
    push_fetch(32'h400, c + 1);                                     push_ack(1'b1, 32'hCAFE_0001);
    push_data(32'h3000_0000, 1'b0, 4'b1100, 32'h1111_1111, c + 2);  push_ack(1'b0, 32'hCAFE_0001);
    push_fetch(32'h400, c + 3);                                     push_ack(1'b1, 32'hCAFE_0001);
    push_data(32'h3000_0000, 1'b0, 4'b1100, 32'h1111_1111, c + 4);  push_ack(1'b0, 32'hCAFE_0001);
`else
    for (int k = 0; k < 4; k++) begin
      push_data(32'h3000_0000, 1'b0, 4'b1100, 32'h1111_1111, c + 1 + k);
      push_ack(1'b0, 32'hCAFE_0001);
    end
`endif
    push_fetch(32'h400, c + 5);
    push_ack(1'b1, 32'hCAFE_0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) i_data_cyc = 1'b0;
    end
    wait_ack(1'b1);
    i_fetch_cyc = 1'b0;
    tick();

    // Abort while waiting: FLUSH swallows the ack, redirected fetch follows it
    mem_wait = 3; mem_rdata = 32'h0000_0093;
    c = cyc_no;
    i_fetch_addr = 32'h200; i_fetch_cyc = 1'b1;
    push_fetch(32'h200, c + 1);
    push_fetch(32'h300, c + 5);
    push_ack(1'b1, 32'h0000_00A3);
    tick();
    i_fetch_abort = 1'b1; i_fetch_addr = 32'h300;
    tick();
    i_fetch_abort = 1'b0;
    repeat (3) tick();
    mem_rdata = 32'h0000_00A3;
    wait_ack(1'b1);
    i_fetch_cyc = 1'b0;
    tick();

    // Abort coinciding with the ack: suppressed, no FLUSH
    mem_wait = 1; mem_rdata = 32'h0000_0017;
    c = cyc_no;
    i_fetch_addr = 32'h500; i_fetch_cyc = 1'b1;
    push_fetch(32'h500, c + 1);
    push_fetch(32'h600, c + 3);
    push_ack(1'b1, 32'h0000_0027);
    tick();
    tick();
    i_fetch_abort = 1'b1; i_fetch_addr = 32'h600;
    tick();
    i_fetch_abort = 1'b0; mem_rdata = 32'h0000_0027;
    wait_ack(1'b1);
    i_fetch_cyc = 1'b0;
    tick();

    // Reset during a DATA wait; a late memory ack must be ignored
    mem_wait = 3; mem_rdata = 32'h0BAD_0BAD;
    c = cyc_no;
    i_data_addr = 32'h4000_0008; i_data_we = 1'b0; i_data_sel = 4'hF;
    i_data_wdata = 32'h55AA_55AA; i_data_cyc = 1'b1;
    push_data(32'h4000_0008, 1'b0, 4'hF, 32'h55AA_55AA, c + 1);
    tick();
    tick();
    i_reset_n = 1'b0; i_data_cyc = 1'b0;
    exp_wdata = '0;
    tick();
    i_reset_n = 1'b1; force_ack = 1'b1;
    tick();
    force_ack = 1'b0; mem_wait = 0; mem_rdata = 32'h0000_0033;
    tick();
    c = cyc_no;
    i_fetch_addr = 32'h700; i_fetch_cyc = 1'b1;
    push_fetch(32'h700, c + 1);
    push_ack(1'b1, 32'h0000_0033);
    wait_ack(1'b1);
    i_fetch_cyc = 1'b0;
    repeat (3) tick();
    done = 1'b1;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
